// File: rtl/ram_requester.sv
// Single-word SRAM access initiator: turns a valid/ready request into a sequenced
// active-low enable/strobe access and returns a one-cycle response (data or timeout).
module ram_requester #(
    parameter int unsigned SETUP_CYCLES = 1,
    parameter int unsigned TIMEOUT      = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [16:0] req_addr,
    input  logic [15:0] req_wdata,
    output logic        rsp_valid,
    output logic [15:0] rsp_rdata,
    output logic        rsp_err,
    output logic [7:0]  err_count,
    output logic        mem_en_n,
    output logic        mem_re_n,
    output logic        mem_we_n,
    output logic [16:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    input  logic        mem_done
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETUP   = 2'd1,
        ST_ACCESS  = 2'd2,
        ST_RELEASE = 2'd3
    } state_e;

    localparam int TW = (TIMEOUT > 32'd1) ? $clog2(TIMEOUT) : 1;
    localparam logic [3:0]    SETUP_LAST   = 4'(SETUP_CYCLES - 32'd1);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'((TIMEOUT > 32'd0) ? (TIMEOUT - 32'd1) : 32'd0);

    state_e        state_q,     state_d;
    logic          write_q,     write_d;
    logic [3:0]    setup_cnt_q, setup_cnt_d;
    logic [TW-1:0] timer_q,     timer_d;
    logic          mem_en_n_q,  mem_en_n_d;
    logic          mem_re_n_q,  mem_re_n_d;
    logic          mem_we_n_q,  mem_we_n_d;
    logic [16:0]   mem_addr_q,  mem_addr_d;
    logic [15:0]   mem_wdata_q, mem_wdata_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic [15:0]   rsp_rdata_q, rsp_rdata_d;
    logic          rsp_err_q,   rsp_err_d;
    logic [7:0]    err_count_q, err_count_d;
    logic          timeout_hit_s;

    // Timeout fires on the ACCESS edge that completes the TIMEOUT-th cycle.
    assign timeout_hit_s = (TIMEOUT != 32'd0) && (timer_q == TIMEOUT_LAST);

    // Next-state and registered-output computation for the access sequencer.
    always_comb begin
        state_d     = state_q;
        write_d     = write_q;
        setup_cnt_d = setup_cnt_q;
        timer_d     = timer_q;
        mem_en_n_d  = mem_en_n_q;
        mem_re_n_d  = mem_re_n_q;
        mem_we_n_d  = mem_we_n_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        err_count_d = err_count_q;

        case (state_q)
            ST_IDLE: begin
                mem_en_n_d = 1'b1;
                mem_re_n_d = 1'b1;
                mem_we_n_d = 1'b1;
                if (req_valid) begin
                    write_d     = req_write;
                    mem_addr_d  = req_addr;
                    mem_wdata_d = req_write ? req_wdata : 16'h0000;
                    setup_cnt_d = 4'd0;
                    timer_d     = '0;
                    state_d     = ST_SETUP;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SETUP: begin
                if (setup_cnt_q == SETUP_LAST) begin
                    mem_en_n_d = 1'b0;
                    mem_re_n_d = write_q;
                    mem_we_n_d = ~write_q;
                    state_d    = ST_ACCESS;
                end else begin
                    setup_cnt_d = setup_cnt_q + 4'd1;
                end
            end
            ST_ACCESS: begin
                // A completing handshake takes priority over an expiring timer.
                if (mem_done) begin
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = write_q ? 16'h0000 : mem_rdata;
                    rsp_err_d   = 1'b0;
                    mem_en_n_d  = 1'b1;
                    mem_re_n_d  = 1'b1;
                    mem_we_n_d  = 1'b1;
                    state_d     = ST_RELEASE;
                end else if (timeout_hit_s) begin
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = 16'h0000;
                    rsp_err_d   = 1'b1;
                    err_count_d = (err_count_q == 8'hFF) ? 8'hFF : (err_count_q + 8'd1);
                    mem_en_n_d  = 1'b1;
                    mem_re_n_d  = 1'b1;
                    mem_we_n_d  = 1'b1;
                    state_d     = ST_RELEASE;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            ST_RELEASE: begin
                // The memory path must drop done before another access may start.
                if (mem_done) begin
                    state_d = ST_RELEASE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d    = ST_IDLE;
                mem_en_n_d = 1'b1;
                mem_re_n_d = 1'b1;
                mem_we_n_d = 1'b1;
            end
        endcase
    end

    // State and output registers; reset forces all strobes inactive immediately.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            write_q     <= 1'b0;
            setup_cnt_q <= 4'd0;
            timer_q     <= '0;
            mem_en_n_q  <= 1'b1;
            mem_re_n_q  <= 1'b1;
            mem_we_n_q  <= 1'b1;
            mem_addr_q  <= 17'h00000;
            mem_wdata_q <= 16'h0000;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 16'h0000;
            rsp_err_q   <= 1'b0;
            err_count_q <= 8'h00;
        end else begin
            state_q     <= state_d;
            write_q     <= write_d;
            setup_cnt_q <= setup_cnt_d;
            timer_q     <= timer_d;
            mem_en_n_q  <= mem_en_n_d;
            mem_re_n_q  <= mem_re_n_d;
            mem_we_n_q  <= mem_we_n_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            err_count_q <= err_count_d;
        end
    end

    assign req_ready = (state_q == ST_IDLE);
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign err_count = err_count_q;
    assign mem_en_n  = mem_en_n_q;
    assign mem_re_n  = mem_re_n_q;
    assign mem_we_n  = mem_we_n_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: doc/ram_requester.md
Name: ram_requester

Overview:
- Clocked initiator that issues single-word read/write transactions to the dual-bank SRAM access path and waits for its `done` handshake.
- It sits between a host command source (UART command decoder or CPU memory stage) and the bank-select memory path.
- It converts a valid/ready request stream into properly sequenced active-low enable and strobe signals.
- It returns a one-cycle response carrying the read data or a timeout error.

Parameters:
- SETUP_CYCLES, 1: cycles the address and write data are held stable before the enable and strobe assert (range 1..15).
- TIMEOUT, 64: maximum ACCESS cycles to wait for mem_done; 0 disables the timeout.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  1  host request present.
- req_ready  out  1  block can accept a request; high only in IDLE.
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  17  word address; bit 16 selects the bank (0 = ram1, 1 = ram2).
- req_wdata  in  16  write data.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_rdata  out  16  read data; 0 for writes and on error.
- rsp_err  out  1  response was a timeout; qualified by rsp_valid.
- err_count  out  8  saturating count of timeouts.
- mem_en_n  out  1  active-low memory enable.
- mem_re_n  out  1  active-low read strobe.
- mem_we_n  out  1  active-low write strobe.
- mem_addr  out  17  registered address to the memory path.
- mem_wdata  out  16  registered write data.
- mem_rdata  in  16  read data from the memory path.
- mem_done  in  1  access complete, active high.

Behaviour:
- Reset (rst = 0, asynchronous):
  - State goes to IDLE.
  - mem_en_n, mem_re_n and mem_we_n go to 1 immediately, without waiting for a clock edge.
  - mem_addr = 0, mem_wdata = 0, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0, err_count = 0, all internal counters 0.
- All outputs are registered except req_ready, which equals (state == IDLE).
- States: IDLE, SETUP, ACCESS, RELEASE.
- IDLE:
  - On an edge with req_valid = 1: latch req_write, drive mem_addr = req_addr and mem_wdata = req_wdata (mem_wdata = 0 for reads).
  - Clear the counters and go to SETUP.
  - Strobes stay high.
- SETUP:
  - Strobes stay high; address and data are stable.
  - Stay for exactly SETUP_CYCLES cycles, then go to ACCESS.
  - On that transition, register mem_en_n = 0 plus mem_re_n = 0 (read) or mem_we_n = 0 (write); never both.
- ACCESS:
  - mem_done is sampled every edge.
  - mem_done = 1: capture rsp_rdata = mem_rdata on a read (0 on a write), set rsp_err = 0, set rsp_valid = 1, deassert all strobes, go to RELEASE.
  - TIMEOUT != 0 and the timer reaches TIMEOUT cycles in ACCESS: set rsp_rdata = 0, rsp_err = 1, rsp_valid = 1; increment err_count, saturating at 255; deassert strobes; go to RELEASE.
  - mem_done = 1 on the same edge the timeout expires: done wins, no error.
- RELEASE:
  - rsp_valid is cleared after one cycle; rsp_rdata and rsp_err hold until the next response.
  - Stay while mem_done = 1, because the memory path must drop done once the enable is released.
  - Go to IDLE on the first edge with mem_done = 0.
- Latency: with done seen on the first ACCESS edge, rsp_valid rises SETUP_CYCLES + 1 edges after the accepting edge.
- The minimum request-to-request period is SETUP_CYCLES + 3 cycles.
- Requests presented while req_ready = 0 are not accepted; the host must hold req_valid.
- mem_addr and mem_wdata are constant from acceptance until IDLE is re-entered.
- Bank bit 16 is passed through unchanged; no address arithmetic.

Test Plan:
- Write, bank 0: req addr 0x00012, data 0xBEEF, SETUP_CYCLES = 1; model asserts done 3 cycles after mem_we_n falls.
  - mem_addr = 0x00012 and mem_wdata = 0xBEEF, stable one cycle before the strobes.
  - mem_we_n is low, mem_re_n stays high.
  - One rsp_valid pulse, rsp_err = 0, rsp_rdata = 0.
- Read, bank 1: req addr 0x10005; model returns 0x1234 with done.
  - mem_addr = 0x10005, mem_re_n low, mem_we_n high.
  - rsp_rdata = 0x1234, rsp_err = 0.
- Timeout: TIMEOUT = 16, mem_done held 0.
  - Strobes stay low for exactly 16 cycles, then release.
  - rsp_valid with rsp_err = 1, rsp_rdata = 0, err_count = 1, return to IDLE.
- Back-to-back: req_valid held high with two requests, the second a write of 0x5555.
  - req_ready is low from acceptance until RELEASE exits.
  - The second request is accepted exactly on re-entry to IDLE; no overlap of strobes.
- Reset mid-ACCESS: rst pulled low while mem_en_n = 0.
  - mem_en_n, mem_re_n and mem_we_n go high without a clock edge.
  - No rsp_valid pulse.
  - req_ready = 1 on the first cycle after rst returns high.
- Done stuck high: mem_done stays 1 for 5 cycles after the response.
  - rsp_valid is exactly one cycle.
  - The block stays in RELEASE with req_ready = 0 until mem_done = 0, then returns to IDLE.
